// File: rtl/game_ctrl_pkg.sv
// Shared constants for the game controller: FSM encoding and default widths.
package game_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_PLAY  = 2'b01;
    localparam logic [1:0] ST_DYING = 2'b10;
    localparam logic [1:0] ST_OVER  = 2'b11;

    localparam int SCORE_W_DEF = 10;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_PLAY  = ST_PLAY,
        S_DYING = ST_DYING,
        S_OVER  = ST_OVER
    } state_e;

endpackage

// File: rtl/game_ctrl_death_timer.sv
// Counts frame ticks while not cleared; done fires on the tick that reaches limit.
module death_timer #(
    parameter int W = 6
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         tick_i,
    input  logic [W-1:0] limit_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W:0]   nxt;

    always_comb begin
        nxt    = {1'b0, cnt_q} + (W+1)'(1);
        done_o = tick_i && !clear_i && (nxt >= {1'b0, limit_i});
        cnt_d  = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (tick_i && !done_o)
            cnt_d = nxt[W-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/game_ctrl.sv
// Game flow controller: start/play/dying/over sequencing, scoring and high score.
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int V_TOT        = 525,
    parameter int GROUND_POS   = 435,
    parameter int SKY_POS      = 0,
    parameter int B_WIDTH      = 16,
    parameter int DEATH_FRAMES = 60,
    parameter int SCORE_W      = SCORE_W_DEF
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iBtnStart,
    input  logic                     iFrameTick,
    input  logic [$clog2(V_TOT)-1:0] iBirdPos,
    input  logic                     iPipeHit,
    input  logic                     iPipePassed,
    output logic                     oBirdMove,
    output logic                     oBirdDead,
    output logic                     oPipeMove,
    output logic                     oRstGame,
    output logic [SCORE_W-1:0]       oScore,
    output logic [SCORE_W-1:0]       oHiScore,
    output logic [1:0]               oState
);

    localparam int PW = $clog2(V_TOT);
    localparam int TW = $clog2(DEATH_FRAMES + 1);

    state_e             state_q;
    logic               btn_q;
    logic               rst_game_q;
    logic               move_q;
    logic               dead_q;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] hi_q;

    logic        start;
    logic [PW:0] bottom;
    logic        collide;
    logic        tmr_done;

    assign start = iBtnStart && !btn_q;

    // Extra bit keeps the bird's bottom edge from wrapping near V_TOT
    assign bottom  = {1'b0, iBirdPos} + (PW+1)'(B_WIDTH);
    assign collide = iPipeHit
                  || (iBirdPos <= PW'(SKY_POS))
                  || (bottom >= (PW+1)'(GROUND_POS));

    death_timer #(
        .W (TW)
    ) u_death_timer (
        .clk_i   (iClk),
        .rst_i   (iRst),
        .clear_i (state_q != S_DYING),
        .tick_i  (iFrameTick),
        .limit_i (TW'(DEATH_FRAMES)),
        .done_o  (tmr_done)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q    <= S_IDLE;
            btn_q      <= 1'b0;
            rst_game_q <= 1'b0;
            move_q     <= 1'b0;
            dead_q     <= 1'b0;
            score_q    <= '0;
            hi_q       <= '0;
        end else begin
            btn_q      <= iBtnStart;
            rst_game_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        rst_game_q <= 1'b1;
                        score_q    <= '0;
                        move_q     <= 1'b1;
                        state_q    <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (collide) begin
                        state_q <= S_DYING;
                        move_q  <= 1'b0;
                        dead_q  <= 1'b1;
                        if (score_q > hi_q)
                            hi_q <= score_q;
                    end else if (iPipePassed && (score_q != '1)) begin
                        score_q <= score_q + SCORE_W'(1);
                    end
                end
                S_DYING: begin
                    if (tmr_done)
                        state_q <= S_OVER;
                end
                S_OVER: begin
                    if (start) begin
                        rst_game_q <= 1'b1;
                        dead_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign oState    = state_q;
    assign oRstGame  = rst_game_q;
    assign oBirdMove = move_q;
    assign oPipeMove = move_q;
    assign oBirdDead = dead_q;
    assign oScore    = score_q;
    assign oHiScore  = hi_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed vector bench for game_ctrl with a short death interval.
module tb_game_ctrl;

    localparam int SW = 10;
    localparam int PW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn;
    logic          tick;
    logic [PW-1:0] pos;
    logic          hit;
    logic          pass;
    logic          bmove;
    logic          dead;
    logic          pmove;
    logic          rgame;
    logic [SW-1:0] score;
    logic [SW-1:0] hi;
    logic [1:0]    st;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    game_ctrl #(
        .DEATH_FRAMES (3)
    ) dut (
        .iClk        (clk),
        .iRst        (rst),
        .iBtnStart   (btn),
        .iFrameTick  (tick),
        .iBirdPos    (pos),
        .iPipeHit    (hit),
        .iPipePassed (pass),
        .oBirdMove   (bmove),
        .oBirdDead   (dead),
        .oPipeMove   (pmove),
        .oRstGame    (rgame),
        .oScore      (score),
        .oHiScore    (hi),
        .oState      (st)
    );

    typedef struct {
        logic btn;
        logic tick;
        logic hit;
        logic pass;
        int   pos;
        int   st;
        int   rg;
        int   mv;
        int   dead;
        int   sc;
        int   hi;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic b, logic t, logic h, logic p, int ps,
                                int s, int r, int m, int d, int sc, int h2);
        vec_t v;
        v.btn = b; v.tick = t; v.hit = h; v.pass = p; v.pos = ps;
        v.st = s; v.rg = r; v.mv = m; v.dead = d; v.sc = sc; v.hi = h2;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag, int s, int r, int m, int d, int sc, int h);
        chk({tag, " state"}, int'(st), s);
        chk({tag, " rstgame"}, int'(rgame), r);
        chk({tag, " birdmove"}, int'(bmove), m);
        chk({tag, " pipemove"}, int'(pmove), m);
        chk({tag, " dead"}, int'(dead), d);
        chk({tag, " score"}, int'(score), sc);
        chk({tag, " hiscore"}, int'(hi), h);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        btn = 0; tick = 0; hit = 0; pass = 0; pos = 10'd200;
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        #12;
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        //          btn tk hit ps pos  st rg mv dd sc hi
        tv.push_back(mk(1, 0, 0, 0, 200, 1, 1, 1, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 200, 1, 0, 1, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 200, 1, 0, 1, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 1, 200, 1, 0, 1, 0, 2, 0));
        tv.push_back(mk(1, 0, 0, 1, 200, 1, 0, 1, 0, 3, 0));
        tv.push_back(mk(0, 0, 0, 1, 200, 1, 0, 1, 0, 4, 0));
        tv.push_back(mk(0, 0, 0, 1, 200, 1, 0, 1, 0, 5, 0));
        tv.push_back(mk(0, 0, 1, 1, 200, 2, 0, 0, 1, 5, 5));
        tv.push_back(mk(0, 1, 0, 0, 200, 2, 0, 0, 1, 5, 5));
        tv.push_back(mk(1, 0, 0, 0, 200, 2, 0, 0, 1, 5, 5));
        tv.push_back(mk(0, 1, 0, 0, 200, 2, 0, 0, 1, 5, 5));
        tv.push_back(mk(0, 1, 0, 0, 200, 3, 0, 0, 1, 5, 5));
        tv.push_back(mk(1, 0, 0, 0, 200, 0, 1, 0, 0, 5, 5));
        tv.push_back(mk(1, 0, 0, 0, 200, 0, 0, 0, 0, 5, 5));
        tv.push_back(mk(1, 0, 0, 0, 200, 0, 0, 0, 0, 5, 5));
        tv.push_back(mk(0, 0, 0, 0, 200, 0, 0, 0, 0, 5, 5));
        tv.push_back(mk(1, 0, 0, 0, 200, 1, 1, 1, 0, 0, 5));
        tv.push_back(mk(0, 0, 0, 0, 419, 2, 0, 0, 1, 0, 5));
        tv.push_back(mk(0, 1, 0, 0, 200, 2, 0, 0, 1, 0, 5));
        tv.push_back(mk(0, 1, 0, 0, 200, 2, 0, 0, 1, 0, 5));
        tv.push_back(mk(0, 1, 0, 0, 200, 3, 0, 0, 1, 0, 5));
        tv.push_back(mk(1, 0, 0, 0, 200, 0, 1, 0, 0, 0, 5));
        tv.push_back(mk(0, 0, 0, 0, 200, 0, 0, 0, 0, 0, 5));
        tv.push_back(mk(1, 0, 0, 0, 200, 1, 1, 1, 0, 0, 5));
        tv.push_back(mk(0, 0, 0, 0, 418, 1, 0, 1, 0, 0, 5));
        tv.push_back(mk(0, 0, 0, 0, 0,   2, 0, 0, 1, 0, 5));

        foreach (tv[i]) begin
            btn  = tv[i].btn;
            tick = tv[i].tick;
            hit  = tv[i].hit;
            pass = tv[i].pass;
            pos  = PW'(tv[i].pos);
            step();
            chk_all($sformatf("vec%0d", i), tv[i].st, tv[i].rg, tv[i].mv,
                    tv[i].dead, tv[i].sc, tv[i].hi);
        end

        // Async reset mid-PLAY with score 7
        idle_in();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        step();
        btn = 1;
        step();
        btn = 0;
        pass = 1;
        for (int k = 0; k < 7; k++) step();
        pass = 0;
        step();
        chk("pre-reset score", int'(score), 7);
        chk("pre-reset state", int'(st), 1);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk_all("after rst", 0, 0, 0, 0, 0, 0);

        // Score saturation and high-score capture at full scale
        btn = 1;
        step();
        chk("sat start state", int'(st), 1);
        btn = 0;
        pass = 1;
        for (int k = 0; k < 1030; k++) step();
        chk("sat score", int'(score), 1023);
        pass = 0;
        hit = 1;
        step();
        hit = 0;
        chk_all("sat hit", 2, 0, 0, 1, 1023, 1023);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 The block SHALL expose parameter V_TOT, default 525, meaning total vertical lines; it sets the bird-position width $clog2(V_TOT).
REQ-002 The block SHALL expose parameter GROUND_POS, default 435, meaning the first line of the ground.
REQ-003 The block SHALL expose parameter SKY_POS, default 0, meaning the top playable line.
REQ-004 The block SHALL expose parameter B_WIDTH, default 16, meaning bird sprite height in lines.
REQ-005 The block SHALL expose parameter DEATH_FRAMES, default 60, meaning the number of frame ticks spent in DYING.
REQ-006 The block SHALL expose parameter SCORE_W, default 10, meaning score width in bits.
REQ-007 Port iClk, input, 1 bit: the single system clock; all logic SHALL be clocked on its rising edge.
REQ-008 Port iRst, input, 1 bit: reset, asynchronous and active-high.
REQ-009 Port iBtnStart, input, 1 bit: start button, level, already synchronised.
REQ-010 Port iFrameTick, input, 1 bit: one-cycle pulse once per video frame.
REQ-011 Port iBirdPos, input, $clog2(V_TOT) bits: top line of the bird.
REQ-012 Port iPipeHit, input, 1 bit: bird/pipe overlap, level.
REQ-013 Port iPipePassed, input, 1 bit: one-cycle pulse when a pipe is cleared.
REQ-014 Port oBirdMove, output, 1 bit: enable to the bird position counter.
REQ-015 Port oBirdDead, output, 1 bit: death flag.
REQ-016 Port oPipeMove, output, 1 bit: enable to the pipe scroller.
REQ-017 Port oRstGame, output, 1 bit: one-cycle soft reset of the bird and pipes.
REQ-018 Port oScore, output, SCORE_W bits: current score.
REQ-019 Port oHiScore, output, SCORE_W bits: best score since iRst.
REQ-020 Port oState, output, 2 bits: FSM state.

Function
REQ-021 The FSM SHALL have four states encoded IDLE=00, PLAY=01, DYING=10, OVER=11.
REQ-022 The start event SHALL be the rising edge of iBtnStart, detected with a registered copy of the previous value; a held button SHALL produce exactly one event.
REQ-023 In IDLE, a start event SHALL pulse oRstGame for 1 cycle, clear oScore, and enter PLAY on the next cycle.
REQ-024 In PLAY, oBirdMove and oPipeMove SHALL be 1; in every other state both SHALL be 0.
REQ-025 In PLAY, a collision is iPipeHit=1, or iBirdPos<=SKY_POS, or iBirdPos+B_WIDTH>=GROUND_POS.
REQ-026 The sum iBirdPos+B_WIDTH SHALL be computed one bit wider than iBirdPos so it cannot wrap.
REQ-027 A collision SHALL cause entry into DYING on the next cycle.
REQ-028 In PLAY, iPipePassed SHALL increment oScore by 1, saturating at 2^SCORE_W-1.
REQ-029 If a collision and iPipePassed occur in the same cycle, the collision SHALL win and the score SHALL NOT increment.
REQ-030 On entry to DYING, oHiScore SHALL be loaded with oScore if oScore>oHiScore.
REQ-031 oBirdDead SHALL be 1 in DYING and OVER, and 0 otherwise.
REQ-032 In DYING, a timer SHALL count iFrameTick pulses; after DEATH_FRAMES pulses the FSM SHALL enter OVER.
REQ-033 Start events SHALL be ignored in PLAY and DYING.
REQ-034 In OVER, a start event SHALL pulse oRstGame for 1 cycle and enter IDLE; oScore SHALL hold until the next start from IDLE.
REQ-035 All outputs SHALL be registered, giving 1-cycle latency from an input to the output change.

Reset
REQ-036 iRst=1 SHALL asynchronously force: state IDLE, oScore=0, oHiScore=0, death timer=0, edge register=0, oRstGame=0, oBirdMove=0, oPipeMove=0, oBirdDead=0.
REQ-037 iRst asserted mid-PLAY or mid-DYING SHALL abort to IDLE with no oRstGame pulse.
REQ-038 oRstGame SHALL NOT clear oHiScore.

Structure
REQ-039 The state encoding localparams and the default SCORE_W SHALL live in the shared game constants package.
REQ-040 The DYING frame timer SHALL be one sub-module, death_timer, with inputs clear, tick and limit and output done.

Verification
REQ-041 Reset followed by a start pulse: oRstGame is high for 1 cycle, oState goes 00->01, and oBirdMove=oPipeMove=1.
REQ-042 In PLAY with iBirdPos=419 (419+16=435): DYING is entered next cycle, oBirdDead=1, and both move enables are 0.
REQ-043 Five iPipePassed pulses, then iPipeHit asserted in the same cycle as a sixth pulse: oScore=5 and oHiScore=5.
REQ-044 In DYING with DEATH_FRAMES=3: OVER is entered exactly after the 3rd iFrameTick, and a start press during DYING is ignored.
REQ-045 Start held high across OVER->IDLE: only one event occurs (OVER->IDLE only); a release then press moves IDLE->PLAY with oScore=0 and oHiScore kept.
REQ-046 iRst asserted asynchronously mid-PLAY with oScore=7: all outputs go to 0 immediately and the state is IDLE.
